l1_tlb_entry_array: RTL and testbench
=====================================

Name: l1_tlb_entry_array

Overview:
- 8-entry fully-associative L1 TLB tag/PPN store with PTW refill FSM and tree pseudo-LRU replacement.
- Directly upstream of the PPN select stage: drives its ppns_0..7, passthrough_ppn and one-hot hitsVec inputs.
- On a lookup miss, issues one PTW request, installs the returned translation in the victim entry, and returns to lookup.

Parameters:
- ENTRIES, 8, number of entries; fixed at 8 to match the PPN select stage. hitsVec width is ENTRIES+1.
- VPN_BITS, 27, virtual page number width (Sv39).
- PPN_BITS, 20, physical page number width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- io_req_valid  in  1  lookup request this cycle.
- io_req_vpn  in  27  lookup VPN.
- io_req_passthrough  in  1  VM disabled; translation bypassed.
- io_req_ready  out  1  high only in IDLE.
- io_resp_miss  out  1  lookup missed; refill starts next cycle.
- io_refill_fault  out  1  one-cycle pulse when the PTW returns an error.
- ppns_0 .. ppns_7  out  20 each  stored PPN per entry.
- passthrough_ppn  out  20  io_req_vpn[19:0].
- hitsVec  out  9  [7:0] = entry hits, [8] = passthrough hit.
- io_ptw_req_valid  out  1  refill request.
- io_ptw_req_ready  in  1  PTW accepts the request.
- io_ptw_req_vpn  out  27  latched miss VPN.
- io_ptw_resp_valid  in  1  PTW response.
- io_ptw_resp_ppn  in  20  refilled PPN.
- io_ptw_resp_error  in  1  page fault; do not install.
- io_flush  in  1  sfence: invalidate all entries.

Behaviour:
- State per entry: valid bit, 27-bit tag, 20-bit PPN. Also a 7-bit PLRU tree, a 2-bit FSM, a 27-bit miss VPN register and a drop flag.
- Reset (reset=0 at a clock edge):
  - all valid bits, tags, PPNs, PLRU, miss VPN and drop flag cleared; FSM goes to IDLE.
  - Outputs after reset: ppns_* = 0, hitsVec = 0, io_ptw_req_valid = 0, io_resp_miss = 0, io_refill_fault = 0, io_req_ready = 1.
  - Reset mid-refill abandons the refill; any later PTW response is ignored while in IDLE.
- Lookup is combinational, zero latency, valid only in IDLE:
  - hitsVec[i] = io_req_valid & !io_req_passthrough & valid[i] & (tag[i] == io_req_vpn).
  - hitsVec[8] = io_req_valid & io_req_passthrough.
  - Outside IDLE, hitsVec = 0 and io_resp_miss = 0.
  - At most one bit of hitsVec is set. Entries are installed only after a miss on that VPN, so duplicates cannot occur.
- io_resp_miss = IDLE & io_req_valid & !io_req_passthrough & no entry hit.
- FSM:
  - IDLE: on miss, latch io_req_vpn into the miss VPN register and go to REQ.
  - REQ: io_ptw_req_valid = 1 and io_ptw_req_vpn holds steady. Go to WAIT on the cycle io_ptw_req_ready = 1.
  - WAIT: when io_ptw_resp_valid = 1, go to IDLE.
    - If error = 0, drop = 0 and io_flush = 0: write valid = 1, tag = miss VPN, PPN = resp PPN into the victim entry, then update PLRU as an access to the victim.
    - If error = 1: pulse io_refill_fault in that cycle; no install.
    - The new entry is visible to lookups from the cycle after the response.
- Victim selection, evaluated at response time:
  - lowest-index invalid entry if one exists;
  - otherwise walk the PLRU tree.
- PLRU tree:
  - bit0 is the root: 0 selects entries 0-3, 1 selects entries 4-7.
  - bits1 and 2 are the second level for the left and right halves.
  - bits3-6 pick within the pairs (0,1), (2,3), (4,5), (6,7); 0 selects the lower index.
  - An access to entry i sets the three bits on its path to point away from i.
  - An IDLE hit updates PLRU at the clock edge, unless io_flush is high that cycle.
- Flush:
  - io_flush = 1 clears all valid bits and PLRU at the edge.
  - A hit in the same cycle is still reported (old state).
  - Flush in REQ or WAIT sets drop = 1: the request continues, because io_ptw_req_valid cannot be retracted, but the response is not installed.
  - Flush coincident with io_ptw_resp_valid also suppresses the install.
  - drop clears on entry to IDLE.
- io_req_ready = (state == IDLE). Requests outside IDLE are ignored; the requester re-presents them.

Test Plan:
- Reset, then lookup vpn 0x0001234 -> hitsVec = 0, io_resp_miss = 1. Next cycle io_ptw_req_valid = 1 with vpn 0x0001234. Ready, then response ppn 0xABCDE -> entry 0 installed; the same lookup now gives hitsVec = 9'h001 and ppns_0 = 0xABCDE.
- Passthrough lookup vpn 0x7FFFFFF -> hitsVec = 9'h100, passthrough_ppn = 0xFFFFF, no miss.
- Fill vpns 0..7, hit entries 0, 2, 4, 6, then miss vpn 8 -> victim is entry 1 (PLRU walk); vpn 1 then misses.
- io_flush asserted during WAIT, then response -> no install; lookup of the same vpn misses again. All ppns_* retain their values, but hitsVec = 0.
- Response with io_ptw_resp_error = 1 -> io_refill_fault pulses for one cycle, no entry becomes valid, FSM returns to IDLE.
- Hold io_ptw_req_ready = 0 for 5 cycles in REQ -> io_ptw_req_valid and the vpn stay stable. Assert reset low in WAIT -> next cycle IDLE, all outputs at reset values, and a late response is ignored.

Source files
------------

// File: rtl/l1_tlb_entry_array_if.sv
// Lookup, PTW refill and PPN-select signals of the L1 TLB entry array.
// The entry array is the slave; the requester/PTW side is the master.
interface l1_tlb_entry_array_if #(
  parameter int VPN_BITS = 27,
  parameter int PPN_BITS = 20
);
  logic                io_req_valid;
  logic [VPN_BITS-1:0] io_req_vpn;
  logic                io_req_passthrough;
  logic                io_req_ready;
  logic                io_resp_miss;
  logic                io_refill_fault;
  logic [PPN_BITS-1:0] ppns_0, ppns_1, ppns_2, ppns_3;
  logic [PPN_BITS-1:0] ppns_4, ppns_5, ppns_6, ppns_7;
  logic [PPN_BITS-1:0] passthrough_ppn;
  logic [8:0]          hitsVec;
  logic                io_ptw_req_valid;
  logic                io_ptw_req_ready;
  logic [VPN_BITS-1:0] io_ptw_req_vpn;
  logic                io_ptw_resp_valid;
  logic [PPN_BITS-1:0] io_ptw_resp_ppn;
  logic                io_ptw_resp_error;
  logic                io_flush;

  modport slave (
    input  io_req_valid, io_req_vpn, io_req_passthrough,
           io_ptw_req_ready, io_ptw_resp_valid, io_ptw_resp_ppn,
           io_ptw_resp_error, io_flush,
    output io_req_ready, io_resp_miss, io_refill_fault,
           ppns_0, ppns_1, ppns_2, ppns_3, ppns_4, ppns_5, ppns_6, ppns_7,
           passthrough_ppn, hitsVec, io_ptw_req_valid, io_ptw_req_vpn
  );

  modport master (
    output io_req_valid, io_req_vpn, io_req_passthrough,
           io_ptw_req_ready, io_ptw_resp_valid, io_ptw_resp_ppn,
           io_ptw_resp_error, io_flush,
    input  io_req_ready, io_resp_miss, io_refill_fault,
           ppns_0, ppns_1, ppns_2, ppns_3, ppns_4, ppns_5, ppns_6, ppns_7,
           passthrough_ppn, hitsVec, io_ptw_req_valid, io_ptw_req_vpn
  );
endinterface

// File: rtl/l1_tlb_entry_array.sv
// 8-entry fully-associative L1 TLB: combinational lookup, single-request
// PTW refill FSM, tree pseudo-LRU victim choice.
module l1_tlb_entry_array #(
  parameter int ENTRIES  = 8,
  parameter int VPN_BITS = 27,
  parameter int PPN_BITS = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  l1_tlb_entry_array_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t                             r_state, w_state_nxt;
  logic [ENTRIES-1:0]                 r_valid;
  logic [ENTRIES-1:0][VPN_BITS-1:0]   r_tag;
  logic [ENTRIES-1:0][PPN_BITS-1:0]   r_ppn;
  logic [6:0]                         r_plru;
  logic [VPN_BITS-1:0]                r_miss_vpn;
  logic                               r_drop;

  logic               w_idle, w_lookup, w_miss, w_resp, w_install;
  logic [ENTRIES-1:0] w_hit;
  logic [2:0]         w_hit_idx, w_inv_idx, w_walk, w_victim;

  // Point the three nodes on entry i's path away from it.
  function automatic logic [6:0] plru_touch(input logic [6:0] t, input logic [2:0] i);
    logic [6:0] n;
    n = t;
    n[0] = ~i[2];
    if (i[2]) n[2] = ~i[1];
    else      n[1] = ~i[1];
    n[3'd3 + {1'b0, i[2:1]}] = ~i[0];
    return n;
  endfunction

  assign w_idle   = (r_state == S_IDLE);
  assign w_lookup = w_idle & bus.io_req_valid & ~bus.io_req_passthrough;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    assign w_hit[g] = w_lookup & r_valid[g] & (r_tag[g] == bus.io_req_vpn);
  end

  assign w_miss    = w_lookup & ~(|w_hit);
  assign w_resp    = (r_state == S_WAIT) & bus.io_ptw_resp_valid;
  assign w_install = w_resp & ~bus.io_ptw_resp_error & ~r_drop & ~bus.io_flush;

  always_comb begin
    w_hit_idx = '0;
    w_inv_idx = '0;
    for (int k = ENTRIES - 1; k >= 0; k--) begin
      if (w_hit[k])    w_hit_idx = 3'(k);
      if (!r_valid[k]) w_inv_idx = 3'(k);
    end
    if (r_plru[0]) w_walk = {1'b1, r_plru[2], r_plru[2] ? r_plru[6] : r_plru[5]};
    else           w_walk = {1'b0, r_plru[1], r_plru[1] ? r_plru[4] : r_plru[3]};
    w_victim = (&r_valid) ? w_walk : w_inv_idx;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_miss)                 w_state_nxt = S_REQ;
      S_REQ:   if (bus.io_ptw_req_ready)   w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.io_ptw_resp_valid)  w_state_nxt = S_IDLE;
      default:                             w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_tag      <= '0;
      r_ppn      <= '0;
      r_plru     <= '0;
      r_miss_vpn <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_miss) r_miss_vpn <= bus.io_req_vpn;
      // The PTW request cannot be withdrawn, so a flush mid-refill only poisons the response.
      if (!w_idle && w_state_nxt == S_IDLE) r_drop <= 1'b0;
      else if (!w_idle && bus.io_flush)     r_drop <= 1'b1;
      if (bus.io_flush) begin
        r_valid <= '0;
        r_plru  <= '0;
      end else if (w_install) begin
        r_valid[w_victim] <= 1'b1;
        r_tag[w_victim]   <= r_miss_vpn;
        r_ppn[w_victim]   <= bus.io_ptw_resp_ppn;
        r_plru            <= plru_touch(r_plru, w_victim);
      end else if (|w_hit) begin
        r_plru <= plru_touch(r_plru, w_hit_idx);
      end
    end
  end

  assign bus.io_req_ready     = w_idle;
  assign bus.io_resp_miss     = w_miss;
  assign bus.io_refill_fault  = w_resp & bus.io_ptw_resp_error;
  assign bus.io_ptw_req_valid = (r_state == S_REQ);
  assign bus.io_ptw_req_vpn   = r_miss_vpn;
  assign bus.passthrough_ppn  = bus.io_req_vpn[PPN_BITS-1:0];
  assign bus.hitsVec          = {w_idle & bus.io_req_valid & bus.io_req_passthrough, w_hit};
  assign bus.ppns_0 = r_ppn[0];
  assign bus.ppns_1 = r_ppn[1];
  assign bus.ppns_2 = r_ppn[2];
  assign bus.ppns_3 = r_ppn[3];
  assign bus.ppns_4 = r_ppn[4];
  assign bus.ppns_5 = r_ppn[5];
  assign bus.ppns_6 = r_ppn[6];
  assign bus.ppns_7 = r_ppn[7];
endmodule

// File: tb/tb_l1_tlb_entry_array.sv
// Directed plus randomized bench for l1_tlb_entry_array against a heap-ordered
// PLRU / associative-array reference model.
module tb_l1_tlb_entry_array;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  l1_tlb_entry_array_if bus ();
  l1_tlb_entry_array dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [19:0] d_ppn [8];
  assign d_ppn[0] = bus.ppns_0;
  assign d_ppn[1] = bus.ppns_1;
  assign d_ppn[2] = bus.ppns_2;
  assign d_ppn[3] = bus.ppns_3;
  assign d_ppn[4] = bus.ppns_4;
  assign d_ppn[5] = bus.ppns_5;
  assign d_ppn[6] = bus.ppns_6;
  assign d_ppn[7] = bus.ppns_7;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 request, 2 waiting; PLRU as heap nodes 1..7.
  bit          m_v    [8];
  logic [26:0] m_tag  [8];
  logic [19:0] m_ppn  [8];
  bit          m_node [8];
  int          m_mode;
  logic [26:0] m_mvpn;
  bit          m_drop;

  function automatic int m_lookup();
    for (int i = 0; i < 8; i++)
      if (m_v[i] && m_tag[i] == bus.io_req_vpn) return i;
    return -1;
  endfunction

  task automatic m_touch(input int e);
    int idx = 1;
    for (int l = 2; l >= 0; l--) begin
      int b;
      b = (e >> l) & 1;
      m_node[idx] = (b == 0);
      idx = 2 * idx + b;
    end
  endtask

  function automatic int m_victim();
    int idx = 1;
    for (int i = 0; i < 8; i++) if (!m_v[i]) return i;
    repeat (3) idx = 2 * idx + int'(m_node[idx]);
    return idx - 8;
  endfunction

  always @(posedge clk) begin
    int h, v;
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        m_v[i] = 0; m_tag[i] = '0; m_ppn[i] = '0; m_node[i] = 0;
      end
      m_mode = 0; m_mvpn = '0; m_drop = 0;
    end else begin
      h = m_lookup();
      case (m_mode)
        0: if (bus.io_req_valid && !bus.io_req_passthrough) begin
             if (h >= 0) m_touch(h);
             else begin m_mvpn = bus.io_req_vpn; m_mode = 1; end
           end
        1: begin
             if (bus.io_flush) m_drop = 1;
             if (bus.io_ptw_req_ready) m_mode = 2;
           end
        default: begin
             if (bus.io_flush) m_drop = 1;
             if (bus.io_ptw_resp_valid) begin
               if (!bus.io_ptw_resp_error && !m_drop) begin
                 v = m_victim();
                 m_v[v] = 1; m_tag[v] = m_mvpn; m_ppn[v] = bus.io_ptw_resp_ppn;
                 m_touch(v);
               end
               m_mode = 0; m_drop = 0;
             end
           end
      endcase
      if (bus.io_flush)
        for (int i = 0; i < 8; i++) begin m_v[i] = 0; m_node[i] = 0; end
    end
  end

  always @(negedge clk) if (chk_en) begin
    int h;
    logic [8:0] eh;
    bit emiss;
    eh = '0; emiss = 0; h = -1;
    if (m_mode == 0 && bus.io_req_valid) begin
      if (bus.io_req_passthrough) eh[8] = 1'b1;
      else begin
        h = m_lookup();
        if (h >= 0) eh[h] = 1'b1;
        else emiss = 1;
      end
    end
    check("hitsVec", 64'(bus.hitsVec), 64'(eh));
    check("resp_miss", 64'(bus.io_resp_miss), 64'(emiss));
    check("req_ready", 64'(bus.io_req_ready), 64'(m_mode == 0));
    check("ptw_req_valid", 64'(bus.io_ptw_req_valid), 64'(m_mode == 1));
    check("ptw_req_vpn", 64'(bus.io_ptw_req_vpn), 64'(m_mvpn));
    check("refill_fault", 64'(bus.io_refill_fault),
          64'(m_mode == 2 && bus.io_ptw_resp_valid && bus.io_ptw_resp_error));
    check("passthrough_ppn", 64'(bus.passthrough_ppn), 64'(bus.io_req_vpn[19:0]));
    for (int i = 0; i < 8; i++) check("ppns", 64'(d_ppn[i]), 64'(m_ppn[i]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.io_req_valid = 0; bus.io_req_vpn = '0; bus.io_req_passthrough = 0;
    bus.io_ptw_req_ready = 0; bus.io_ptw_resp_valid = 0; bus.io_ptw_resp_ppn = '0;
    bus.io_ptw_resp_error = 0; bus.io_flush = 0;
  endtask

  task automatic rst_pulse();
    quiet();
    reset = 0;
    step();
    reset = 1;
  endtask

  task automatic refill(input logic [26:0] vpn, input logic [19:0] ppn);
    bus.io_req_valid = 1; bus.io_req_vpn = vpn;
    @(negedge clk); check("refill_miss", 64'(bus.io_resp_miss), 64'd1);
    step();
    bus.io_req_valid = 0; bus.io_ptw_req_ready = 1;
    @(negedge clk); check("refill_vpn", 64'(bus.io_ptw_req_vpn), 64'(vpn));
    step();
    bus.io_ptw_req_ready = 0; bus.io_ptw_resp_valid = 1; bus.io_ptw_resp_ppn = ppn;
    step();
    bus.io_ptw_resp_valid = 0;
  endtask

  initial begin
    quiet();
    reset = 0;
    repeat (2) step();
    chk_en = 1;
    @(negedge clk);
    check("rst_ready", 64'(bus.io_req_ready), 64'd1);
    check("rst_hits", 64'(bus.hitsVec), 64'd0);
    check("rst_ppn0", 64'(bus.ppns_0), 64'd0);
    step();
    reset = 1;

    // First miss and refill into entry 0
    refill(27'h0001234, 20'hABCDE);
    bus.io_req_valid = 1; bus.io_req_vpn = 27'h0001234;
    @(negedge clk);
    check("hit_e0", 64'(bus.hitsVec), 64'h001);
    check("ppn_e0", 64'(bus.ppns_0), 64'hABCDE);
    check("hit_nomiss", 64'(bus.io_resp_miss), 64'd0);
    step();

    // Passthrough
    bus.io_req_vpn = 27'h7FFFFFF; bus.io_req_passthrough = 1;
    @(negedge clk);
    check("pt_hits", 64'(bus.hitsVec), 64'h100);
    check("pt_ppn", 64'(bus.passthrough_ppn), 64'hFFFFF);
    check("pt_miss", 64'(bus.io_resp_miss), 64'd0);
    step();
    rst_pulse();

    // Fill, touch even entries, PLRU victim is entry 1
    for (int i = 0; i < 8; i++) refill(27'(i), 20'(32'h100 + i));
    for (int i = 0; i < 8; i += 2) begin
      bus.io_req_valid = 1; bus.io_req_vpn = 27'(i);
      step();
    end
    bus.io_req_valid = 0;
    refill(27'd8, 20'h55555);
    bus.io_req_valid = 1; bus.io_req_vpn = 27'd8;
    @(negedge clk);
    check("victim_hit", 64'(bus.hitsVec), 64'h002);
    check("victim_ppn", 64'(bus.ppns_1), 64'h55555);
    step();
    bus.io_req_vpn = 27'd1;
    @(negedge clk); check("evicted_miss", 64'(bus.io_resp_miss), 64'd1);
    step();
    rst_pulse();

    // Flush during WAIT drops the response
    refill(27'h10, 20'h0AAAA);
    bus.io_req_valid = 1; bus.io_req_vpn = 27'h20; step();
    bus.io_req_valid = 0; bus.io_ptw_req_ready = 1; step();
    bus.io_ptw_req_ready = 0; bus.io_flush = 1; step();
    bus.io_flush = 0; bus.io_ptw_resp_valid = 1; bus.io_ptw_resp_ppn = 20'h12345; step();
    bus.io_ptw_resp_valid = 0; bus.io_req_valid = 1; bus.io_req_vpn = 27'h20;
    @(negedge clk);
    check("flush_miss", 64'(bus.io_resp_miss), 64'd1);
    check("flush_hits", 64'(bus.hitsVec), 64'd0);
    check("flush_ppn0", 64'(bus.ppns_0), 64'h0AAAA);
    step();
    rst_pulse();

    // Error response
    bus.io_req_valid = 1; bus.io_req_vpn = 27'h30; step();
    bus.io_req_valid = 0; bus.io_ptw_req_ready = 1; step();
    bus.io_ptw_req_ready = 0; bus.io_ptw_resp_valid = 1; bus.io_ptw_resp_error = 1;
    @(negedge clk); check("fault_pulse", 64'(bus.io_refill_fault), 64'd1);
    step();
    bus.io_ptw_resp_valid = 0; bus.io_ptw_resp_error = 0;
    bus.io_req_valid = 1; bus.io_req_vpn = 27'h30;
    @(negedge clk);
    check("fault_end", 64'(bus.io_refill_fault), 64'd0);
    check("fault_ready", 64'(bus.io_req_ready), 64'd1);
    check("fault_noinst", 64'(bus.io_resp_miss), 64'd1);
    step();
    rst_pulse();

    // Stall in REQ, then reset in WAIT and a late response
    bus.io_req_valid = 1; bus.io_req_vpn = 27'h40; step();
    bus.io_req_valid = 0;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 64'(bus.io_ptw_req_valid), 64'd1);
      check("stall_vpn", 64'(bus.io_ptw_req_vpn), 64'h40);
      step();
    end
    bus.io_ptw_req_ready = 1; step();
    bus.io_ptw_req_ready = 0; reset = 0; step();
    reset = 1; bus.io_ptw_resp_valid = 1; bus.io_ptw_resp_ppn = 20'h77777;
    @(negedge clk);
    check("late_ready", 64'(bus.io_req_ready), 64'd1);
    check("late_ptwv", 64'(bus.io_ptw_req_valid), 64'd0);
    check("late_fault", 64'(bus.io_refill_fault), 64'd0);
    step();
    bus.io_ptw_resp_valid = 0; bus.io_req_valid = 1; bus.io_req_vpn = 27'h40;
    @(negedge clk); check("late_ignored", 64'(bus.io_resp_miss), 64'd1);
    step();
    rst_pulse();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset                 = ($urandom_range(0, 299) != 0);
      bus.io_req_valid      = ($urandom_range(0, 3) != 0);
      bus.io_req_vpn        = ($urandom_range(0, 7) != 0) ? 27'($urandom_range(0, 11))
                                                          : 27'($urandom);
      bus.io_req_passthrough = ($urandom_range(0, 9) == 0);
      bus.io_ptw_req_ready  = ($urandom_range(0, 2) == 0);
      bus.io_ptw_resp_valid = ($urandom_range(0, 2) == 0);
      bus.io_ptw_resp_ppn   = 20'($urandom);
      bus.io_ptw_resp_error = ($urandom_range(0, 5) == 0);
      bus.io_flush          = ($urandom_range(0, 29) == 0);
      step();
    end
    quiet();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
